// File: rtl/ram_buffer_pkg.sv
// Shared types and constants for the RAM read-buffer allocation controller.
package ram_buffer_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned BYTE_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_HIT,
    ST_RAM_RD,
    ST_RAM_WAIT,
    ST_ALLOC
  } state_e;

endpackage

// File: rtl/ram_buffer_pri_enc.sv
// Lowest-index priority encoder: one-hot and binary index of the lowest set
// request bit, plus an any-set flag. Outputs are zero when no bit is set.
module ram_buffer_pri_enc #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         onehot_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int unsigned IW = $clog2(N);

  // Scan from bit 0 upward; the first set bit wins.
  always_comb begin
    logic found;
    found    = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        found       = 1'b1;
        onehot_o[i] = 1'b1;
        idx_o       = i[IW-1:0];
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/ram_buffer_alloc_ctrl.sv
// Allocation controller for the RAM read buffer. Accepts one request at a
// time, looks for an address hit among the entries, and either bumps the hit
// entry's reference count or reads the line from RAM into a free entry.
// Optional statistics counters are built when RAM_BUFFER_CTRL_STAT_EN is
// defined.
module ram_buffer_alloc_ctrl
  import ram_buffer_pkg::*;
#(
  parameter int unsigned ENT_NUM    = 16,
  parameter int unsigned RAM_RD_LAT = 1,
  parameter int unsigned RAM_AW     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_vld,
  output logic                       req_rdy,
  input  logic [RAM_AW-1:0]          req_addr,
  input  logic [BYTE_W-1:0]          req_start_byte,
  input  logic [BYTE_W-1:0]          req_end_byte,
  output logic [RAM_AW-1:0]          lookup_addr,
  input  logic [ENT_NUM-1:0]         ent_match,
  input  logic [ENT_NUM-1:0]         ent_free,
  output logic                       ram_rd_en,
  output logic [RAM_AW-1:0]          ram_rd_addr,
  input  logic [DATA_W-1:0]          ram_rd_data,
  output logic [ENT_NUM-1:0]         alloc_en,
  output logic [RAM_AW-1:0]          alloc_addr,
  output logic [DATA_W-1:0]          alloc_data,
  output logic [BYTE_W-1:0]          buff_start_byte,
  output logic [BYTE_W-1:0]          buff_end_byte,
  output logic [ENT_NUM-1:0]         ent_cnt_inc,
  output logic                       rsp_vld,
  output logic                       rsp_hit,
  output logic [$clog2(ENT_NUM)-1:0] rsp_ent
`ifdef RAM_BUFFER_CTRL_STAT_EN
  ,
  output logic [15:0]                stat_hit_cnt,
  output logic [15:0]                stat_miss_cnt,
  output logic [15:0]                stat_stall_cnt
`endif
);

  localparam int unsigned IW = $clog2(ENT_NUM);
  localparam int unsigned CW = $clog2(RAM_RD_LAT + 1);

  state_e              state_q;
  logic [RAM_AW-1:0]   addr_q;
  logic [BYTE_W-1:0]   sb_q;
  logic [BYTE_W-1:0]   eb_q;
  logic [ENT_NUM-1:0]  oh_q;
  logic [IW-1:0]       idx_q;
  logic [CW-1:0]       cnt_q;

  logic [ENT_NUM-1:0]  match_oh;
  logic [IW-1:0]       match_idx;
  logic                match_any;
  logic [ENT_NUM-1:0]  free_oh;
  logic [IW-1:0]       free_idx;
  logic                free_any;

  ram_buffer_pri_enc #(.N(ENT_NUM)) u_match_enc (
    .req_i    (ent_match),
    .onehot_o (match_oh),
    .idx_o    (match_idx),
    .any_o    (match_any)
  );

  ram_buffer_pri_enc #(.N(ENT_NUM)) u_free_enc (
    .req_i    (ent_free),
    .onehot_o (free_oh),
    .idx_o    (free_idx),
    .any_o    (free_any)
  );

  // Control FSM; every output is registered and set on the edge entering
  // the state it belongs to, so pulses line up with the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      sb_q            <= '0;
      eb_q            <= '0;
      oh_q            <= '0;
      idx_q           <= '0;
      cnt_q           <= '0;
      req_rdy         <= 1'b1;
      lookup_addr     <= '0;
      ram_rd_en       <= 1'b0;
      ram_rd_addr     <= '0;
      alloc_en        <= '0;
      alloc_addr      <= '0;
      alloc_data      <= '0;
      buff_start_byte <= '0;
      buff_end_byte   <= '0;
      ent_cnt_inc     <= '0;
      rsp_vld         <= 1'b0;
      rsp_hit         <= 1'b0;
      rsp_ent         <= '0;
    end else begin
      ram_rd_en   <= 1'b0;
      alloc_en    <= '0;
      ent_cnt_inc <= '0;
      rsp_vld     <= 1'b0;
      rsp_hit     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_vld) begin
            addr_q      <= req_addr;
            sb_q        <= req_start_byte;
            eb_q        <= req_end_byte;
            lookup_addr <= req_addr;
            req_rdy     <= 1'b0;
            state_q     <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          // A hit always beats a free entry, including one that shows up
          // while stalled waiting for a free slot.
          if (match_any) begin
            idx_q       <= match_idx;
            ent_cnt_inc <= match_oh;
            rsp_vld     <= 1'b1;
            rsp_hit     <= 1'b1;
            rsp_ent     <= match_idx;
            state_q     <= ST_HIT;
          end else if (free_any) begin
            idx_q       <= free_idx;
            oh_q        <= free_oh;
            ram_rd_en   <= 1'b1;
            ram_rd_addr <= addr_q;
            state_q     <= ST_RAM_RD;
          end
        end
        ST_HIT: begin
          req_rdy <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_RAM_RD: begin
          cnt_q   <= CW'(RAM_RD_LAT);
          state_q <= ST_RAM_WAIT;
        end
        ST_RAM_WAIT: begin
          if (cnt_q == CW'(1)) begin
            alloc_data      <= ram_rd_data;
            alloc_en        <= oh_q;
            alloc_addr      <= addr_q;
            buff_start_byte <= sb_q;
            buff_end_byte   <= eb_q;
            rsp_vld         <= 1'b1;
            rsp_ent         <= idx_q;
            state_q         <= ST_ALLOC;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_ALLOC: begin
          req_rdy <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          req_rdy <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RAM_BUFFER_CTRL_STAT_EN
  // Saturating hit / miss / stall event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit_cnt   <= '0;
      stat_miss_cnt  <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (state_q == ST_HIT && stat_hit_cnt != '1)
        stat_hit_cnt <= stat_hit_cnt + 16'd1;
      if (state_q == ST_ALLOC && stat_miss_cnt != '1)
        stat_miss_cnt <= stat_miss_cnt + 16'd1;
      if (state_q == ST_LOOKUP && !match_any && !free_any && stat_stall_cnt != '1)
        stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_buffer_alloc_ctrl.sv
// Directed, scoreboard-checked bench for ram_buffer_alloc_ctrl.
module tb_ram_buffer_alloc_ctrl;
  import ram_buffer_pkg::*;

  localparam int unsigned ENT = 16;
  localparam int unsigned LAT = 3;
  localparam int unsigned AW  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_vld;
  logic           req_rdy;
  logic [AW-1:0]  req_addr;
  logic [3:0]     req_start_byte, req_end_byte;
  logic [AW-1:0]  lookup_addr;
  logic [ENT-1:0] ent_match, ent_free;
  logic           ram_rd_en;
  logic [AW-1:0]  ram_rd_addr;
  logic [127:0]   ram_rd_data;
  logic [ENT-1:0] alloc_en;
  logic [AW-1:0]  alloc_addr;
  logic [127:0]   alloc_data;
  logic [3:0]     buff_start_byte, buff_end_byte;
  logic [ENT-1:0] ent_cnt_inc;
  logic           rsp_vld, rsp_hit;
  logic [3:0]     rsp_ent;
`ifdef RAM_BUFFER_CTRL_STAT_EN
  logic [15:0]    stat_hit_cnt, stat_miss_cnt, stat_stall_cnt;
`endif

  always #5 clk = ~clk;

  ram_buffer_alloc_ctrl #(.ENT_NUM(ENT), .RAM_RD_LAT(LAT), .RAM_AW(AW)) u_dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_start_byte(req_start_byte), .req_end_byte(req_end_byte),
    .lookup_addr(lookup_addr), .ent_match(ent_match), .ent_free(ent_free),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_data(alloc_data),
    .buff_start_byte(buff_start_byte), .buff_end_byte(buff_end_byte),
    .ent_cnt_inc(ent_cnt_inc), .rsp_vld(rsp_vld), .rsp_hit(rsp_hit), .rsp_ent(rsp_ent)
`ifdef RAM_BUFFER_CTRL_STAT_EN
    , .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  // RAM model: data valid only in the single cycle LAT cycles after the strobe.
  function automatic logic [127:0] line_of(input logic [AW-1:0] a);
    return {16{a}} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  endfunction

  logic [AW-1:0] pipe_a [LAT];
  logic          pipe_v [LAT];

  always @(posedge clk) begin
    pipe_v[0] <= ram_rd_en;
    pipe_a[0] <= ram_rd_addr;
    for (int i = 1; i < int'(LAT); i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end

  assign ram_rd_data = (pipe_v[LAT-1] === 1'b1) ? line_of(pipe_a[LAT-1])
                                                : {8{16'hBAD0}};

  typedef struct {
    logic           hit;
    logic [3:0]     ent;
    logic [ENT-1:0] oh;
    logic [AW-1:0]  addr;
    logic [3:0]     sb;
    logic [3:0]     eb;
  } exp_t;

  exp_t sbq[$];
  int   passed = 0;
  int   total  = 0;
  int   rd_cnt = 0;
  int   al_cnt = 0;
  int   exp_hits = 0, exp_miss = 0, exp_stall = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input logic h, input logic [3:0] e, input logic [ENT-1:0] o,
                              input logic [AW-1:0] a, input logic [3:0] s, input logic [3:0] n);
    exp_t x;
    x.hit = h; x.ent = e; x.oh = o; x.addr = a; x.sb = s; x.eb = n;
    return x;
  endfunction

  // Advance one cycle, sample #1 after the edge and check any response.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (ram_rd_en === 1'b1) rd_cnt++;
    if (alloc_en !== '0) al_cnt++;
    if (rsp_vld === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", {127'd0, rsp_vld}, 128'd0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_hit", {127'd0, rsp_hit}, {127'd0, e.hit});
        chk("rsp_ent", {124'd0, rsp_ent}, {124'd0, e.ent});
        if (e.hit) begin
          chk("ent_cnt_inc", {112'd0, ent_cnt_inc}, {112'd0, e.oh});
          chk("hit_alloc_en", {112'd0, alloc_en}, 128'd0);
        end else begin
          chk("alloc_en", {112'd0, alloc_en}, {112'd0, e.oh});
          chk("alloc_addr", {120'd0, alloc_addr}, {120'd0, e.addr});
          chk("alloc_data", alloc_data, line_of(e.addr));
          chk("buff_start", {124'd0, buff_start_byte}, {124'd0, e.sb});
          chk("buff_end", {124'd0, buff_end_byte}, {124'd0, e.eb});
          chk("miss_cnt_inc", {112'd0, ent_cnt_inc}, 128'd0);
        end
      end
    end else begin
      chk("idle_pulses", {95'd0, alloc_en, ent_cnt_inc, rsp_hit}, 128'd0);
    end
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [3:0] s, input logic [3:0] n);
    chk("req_rdy_idle", {127'd0, req_rdy}, 128'd1);
    req_vld = 1'b1; req_addr = a; req_start_byte = s; req_end_byte = n;
    tick();
    req_vld = 1'b0;
    chk("req_rdy_lookup", {127'd0, req_rdy}, 128'd0);
    chk("lookup_addr", {120'd0, lookup_addr}, {120'd0, a});
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("rsp_timeout", 128'(sbq.size()), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_vld = 1'b0; req_addr = '0; req_start_byte = '0; req_end_byte = '0;
    ent_match = '0; ent_free = '0;
    tick(); tick();
    chk("rst_req_rdy", {127'd0, req_rdy}, 128'd1);
    chk("rst_pulses", {79'd0, ram_rd_en, alloc_en, ent_cnt_inc, rsp_vld, rsp_hit}, 128'd0);
    chk("rst_rsp_ent", {124'd0, rsp_ent}, 128'd0);
    chk("rst_addrs", {104'd0, lookup_addr, ram_rd_addr, alloc_addr}, 128'd0);
    chk("rst_alloc_data", alloc_data, 128'd0);
    chk("rst_bytes", {120'd0, buff_start_byte, buff_end_byte}, 128'd0);
    rst = 1'b0;

    // Reset during RAM_WAIT abandons the miss.
    ent_free = 16'h0080;
    send(8'h55, 4'd1, 4'd2);
    tick();
    chk("abort_rd_en", {127'd0, ram_rd_en}, 128'd1);
    chk("abort_rd_addr", {120'd0, ram_rd_addr}, 128'h55);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_rdy", {127'd0, req_rdy}, 128'd1);
    chk("post_rst_alloc", {111'd0, alloc_en, rsp_vld}, 128'd0);

    // Miss into free entry 4.
    ent_match = '0; ent_free = 16'h0010;
    sbq.push_back(mk(1'b0, 4'd4, 16'h0010, 8'h3C, 4'd0, 4'd15));
    send(8'h3C, 4'd0, 4'd15);
    chk("miss_no_rd_yet", {127'd0, ram_rd_en}, 128'd0);
    tick();
    chk("miss_rd_en", {127'd0, ram_rd_en}, 128'd1);
    chk("miss_rd_addr", {120'd0, ram_rd_addr}, 128'h3C);
    for (int i = 0; i < int'(LAT); i++) begin
      tick();
      chk("miss_wait_rsp", {127'd0, rsp_vld}, 128'd0);
    end
    tick();
    chk("miss_rsp_cycle", 128'(sbq.size()), 128'd0);
    chk("miss_alloc_busy", {127'd0, req_rdy}, 128'd0);
    tick();
    chk("miss_idle", {127'd0, req_rdy}, 128'd1);
    exp_miss++;

    // Multiple matches: lowest index wins, free entries ignored.
    ent_match = 16'h0300; ent_free = 16'hFFFF;
    sbq.push_back(mk(1'b1, 4'd8, 16'h0100, 8'h12, 4'd0, 4'd0));
    send(8'h12, 4'd2, 4'd5);
    chk("hit_not_yet", {127'd0, rsp_vld}, 128'd0);
    tick();
    chk("hit_rsp_cycle", 128'(sbq.size()), 128'd0);
    chk("hit_no_rd", {127'd0, ram_rd_en}, 128'd0);
    tick();
    chk("hit_idle", {127'd0, req_rdy}, 128'd1);
    exp_hits++;

    // Stall five LOOKUP cycles with no free entry, then entry 0 frees up.
    ent_match = '0; ent_free = '0;
    sbq.push_back(mk(1'b0, 4'd0, 16'h0001, 8'h9A, 4'd3, 4'd9));
    send(8'h9A, 4'd3, 4'd9);
    chk("stall_rd0", {127'd0, ram_rd_en}, 128'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_rdy", {127'd0, req_rdy}, 128'd0);
      chk("stall_rd", {127'd0, ram_rd_en}, 128'd0);
    end
    tick();
    ent_free = 16'h0001;
    chk("stall_last_rd", {127'd0, ram_rd_en}, 128'd0);
    tick();
    chk("stall_rd_en", {127'd0, ram_rd_en}, 128'd1);
    chk("stall_rd_addr", {120'd0, ram_rd_addr}, 128'h9A);
    wait_rsp(int'(LAT) + 4);
    tick();
    chk("stall_idle", {127'd0, req_rdy}, 128'd1);
    exp_miss++;
    exp_stall += 5;

    // Stall, then hit and free appear together: hit wins.
    ent_match = '0; ent_free = '0;
    sbq.push_back(mk(1'b1, 4'd2, 16'h0004, 8'h40, 4'd0, 4'd0));
    send(8'h40, 4'd0, 4'd0);
    tick();
    chk("stall2_rdy", {127'd0, req_rdy}, 128'd0);
    tick();
    ent_match = 16'h0004; ent_free = 16'h0001;
    chk("stall2_rd", {127'd0, ram_rd_en}, 128'd0);
    tick();
    chk("race_rsp_cycle", 128'(sbq.size()), 128'd0);
    chk("race_no_rd", {127'd0, ram_rd_en}, 128'd0);
    tick();
    exp_hits++;
    exp_stall += 2;

    // Back-to-back hit on the top entry.
    ent_match = 16'h8000; ent_free = '0;
    sbq.push_back(mk(1'b1, 4'd15, 16'h8000, 8'h77, 4'd0, 4'd0));
    send(8'h77, 4'd0, 4'd0);
    tick();
    chk("top_rsp_cycle", 128'(sbq.size()), 128'd0);
    tick();
    chk("top_idle", {127'd0, req_rdy}, 128'd1);
    exp_hits++;

    ent_match = '0; ent_free = '0;
    tick(); tick();
    chk("total_rd_strobes", 128'(rd_cnt), 128'd3);
    chk("total_alloc_pulses", 128'(al_cnt), 128'd2);
`ifdef RAM_BUFFER_CTRL_STAT_EN
    chk("stat_hit", {112'd0, stat_hit_cnt}, 128'(exp_hits));
    chk("stat_miss", {112'd0, stat_miss_cnt}, 128'(exp_miss));
    chk("stat_stall", {112'd0, stat_stall_cnt}, 128'(exp_stall));
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
